// File: rtl/mem_pkg.sv
// Shared types for the memory-master slice: default sizes, address/data types
// and the transaction state encoding.
package mem_pkg;
  localparam int ADDR_SIZE_DEF = 16;
  localparam int DATA_SIZE_DEF = 8;
  localparam int TIMEOUT_DEF   = 16;

  typedef logic [ADDR_SIZE_DEF-1:0] addr_t;
  typedef logic [DATA_SIZE_DEF-1:0] data_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles spent waiting on the memory; expired flags the last allowed
// wait cycle so the master can give up on that same edge.
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of wait cycles already completed
  assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_master.sv
// Single-outstanding request/response bridge onto a start/ready memory port,
// with a wait timeout and saturating transaction statistics.
module mem_master
  import mem_pkg::*;
#(
  parameter int ADDR_SIZE      = ADDR_SIZE_DEF,
  parameter int DATA_SIZE      = DATA_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rw,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_rw,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_start,
  output logic                 mem_rw,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count,
  output logic [15:0]          err_count
);
  state_t state;
  logic   wd_clear;
  logic   wd_enable;
  logic   wd_expired;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ISSUE always precedes WAIT, so clearing there restarts the count on entry
  assign wd_clear  = (state == ISSUE);
  assign wd_enable = (state == WAIT);

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      mem_start <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rw    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            state     <= ISSUE;
            req_ready <= 1'b0;
            mem_start <= 1'b1;
            mem_rw    <= req_rw;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
          end
        end
        ISSUE: begin
          state     <= WAIT;
          mem_start <= 1'b0;
        end
        WAIT: begin
          // completion is tested first so it wins over a coincident timeout
          if (mem_ready) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rw    <= mem_rw;
            rsp_rdata <= mem_rw ? '0 : mem_rdata;
            rsp_err   <= 1'b0;
            if (mem_rw) wr_count <= sat_inc(wr_count);
            else        rd_count <= sat_inc(rd_count);
          end else if (wd_expired) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rw    <= mem_rw;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            err_count <= sat_inc(err_count);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: behavioural transaction model plus per-cycle compare,
// a one-cycle memory responder and directed scenarios with literal expectations.
module tb_mem_master;
  import mem_pkg::*;

  localparam int TO      = 16;
  localparam int LAT_OK  = 3;
  localparam int LAT_TO  = TO + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_rw;
  addr_t       req_addr;
  data_t       req_wdata;
  logic        rsp_valid, rsp_ready, rsp_rw, rsp_err;
  data_t       rsp_rdata;
  logic        mem_start, mem_rw;
  addr_t       mem_addr;
  data_t       mem_wdata;
  data_t       mem_rdata = 8'h00;
  logic        mem_ready;
  logic [15:0] wr_count, rd_count, err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_master #(.ADDR_SIZE(16), .DATA_SIZE(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_start(mem_start), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Memory responder: answers one cycle after seeing the start strobe
  data_t mm [0:65535];
  logic  mute  = 1'b0;
  logic  stray = 1'b0;
  logic  mem_rdy_m = 1'b0;
  logic  pend = 1'b0;
  logic  p_rw;
  addr_t p_addr;
  data_t p_wdata;
  int    mem_txn = 0;

  assign mem_ready = mem_rdy_m | stray;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 1'b0;
      mem_rdy_m <= 1'b0;
    end else begin
      mem_rdy_m <= 1'b0;
      if (pend && !mute) begin
        mem_rdy_m <= 1'b1;
        if (p_rw) begin
          mm[p_addr] = p_wdata;
          mem_rdata <= 8'hEE;
        end else begin
          mem_rdata <= mm[p_addr];
        end
      end
      pend = 1'b0;
      if (mem_start) begin
        pend    = 1'b1;
        p_rw    = mem_rw;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        mem_txn++;
      end
    end
  end

  // Transaction-level model: one outstanding transaction, fixed latency,
  // expected response computed from a reference memory at acceptance.
  data_t rm [0:65535];
  logic  outst = 1'b0;
  logic  edge_seen = 1'b0;
  int    since = 0;
  int    m_lat = 0;
  logic  m_rw, m_err;
  addr_t m_addr;
  data_t m_wdata, m_rdata;
  int    done_wr = 0, done_rd = 0, done_err = 0;

  always @(posedge clk or negedge rst_n) begin
    logic acc, hs;
    if (!rst_n) begin
      outst = 1'b0; since = 0; edge_seen = 1'b0;
      done_wr = 0; done_rd = 0; done_err = 0;
    end else begin
      acc = req_valid && !outst && edge_seen;
      hs  = outst && (since >= m_lat) && rsp_ready;
      if (hs) begin
        outst = 1'b0;
        if (m_err)     done_err++;
        else if (m_rw) done_wr++;
        else           done_rd++;
      end else if (outst) begin
        since++;
      end
      if (acc) begin
        outst   = 1'b1;
        since   = 0;
        m_rw    = req_rw;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_err   = mute;
        m_lat   = mute ? LAT_TO : LAT_OK;
        m_rdata = (req_rw || mute) ? 8'h00 : rm[req_addr];
        if (req_rw && !mute) rm[req_addr] = req_wdata;
      end
      edge_seen = 1'b1;
    end
  end

  int st_cnt = 0;

  always @(negedge clk) begin
    logic pres;
    if (mem_start) st_cnt++;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mem_start", mem_start, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_fields", {rsp_rw, rsp_err, rsp_rdata}, 0);
      chk("rst_mem_fields", {mem_rw, mem_addr, mem_wdata}, 0);
      chk("rst_counters", wr_count | rd_count | err_count, 0);
    end else begin
      pres = outst && (since >= m_lat);
      chk("rsp_valid", rsp_valid, pres);
      chk("req_ready", req_ready, !outst && edge_seen);
      chk("mem_start", mem_start, outst && since == 0);
      if (pres) begin
        chk("rsp_rw", rsp_rw, m_rw);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
      end else if (outst) begin
        chk("mem_rw", mem_rw, m_rw);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("wr_count", wr_count, done_wr + ((pres && !m_err && m_rw) ? 1 : 0));
      chk("rd_count", rd_count, done_rd + ((pres && !m_err && !m_rw) ? 1 : 0));
      chk("err_count", err_count, done_err + ((pres && m_err) ? 1 : 0));
    end
  end

  task automatic send(input logic rw, input addr_t a, input data_t d);
    int n = 0;
    req_rw = rw; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int stall, output data_t rd, output logic er, output int lat);
    int n = 0;
    rsp_ready = 1'b0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_arrive", rsp_valid, 1);
    lat = n;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  data_t rd;
  logic  er;
  int    lat, t0, nw, nr;

  initial begin
    addr_t ia;
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      ia = i[15:0];
      mm[i] = ia[7:0] ^ ia[15:8];
      rm[i] = ia[7:0] ^ ia[15:8];
    end
    #2;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    chk("release_req_ready", req_ready, 0);
    @(posedge clk); #1;
    chk("first_edge_req_ready", req_ready, 1);

    // write then read back
    send(1'b1, 16'h1234, 8'hA5); get_rsp(0, rd, er, lat);
    chk("wr_err", er, 0);
    send(1'b0, 16'h1234, 8'h00); get_rsp(0, rd, er, lat);
    chk("rd_data", rd, 8'hA5);
    chk("rd_err", er, 0);
    chk("wr_count_1", wr_count, 1);
    chk("rd_count_1", rd_count, 1);

    // single strobe and latency
    st_cnt = 0;
    send(1'b0, 16'h0007, 8'h00); get_rsp(0, rd, er, lat);
    chk("strobe_cycles", st_cnt, 1);
    chk("rsp_latency", lat, 3);
    chk("rd_0007", rd, 8'h07);

    // response backpressure
    t0 = mem_txn;
    send(1'b0, 16'h1234, 8'h00);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rsp_ready = 1'b0;
    repeat (5) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rdata", rsp_rdata, 8'hA5);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_mem_txn", mem_txn - t0, 1);

    // timeout
    mute = 1'b1;
    send(1'b0, 16'h0042, 8'h00); get_rsp(1, rd, er, lat);
    mute = 1'b0;
    chk("to_latency", lat, LAT_TO);
    chk("to_err", er, 1);
    chk("to_rdata", rd, 8'h00);
    chk("to_err_count", err_count, 1);

    // reset during WAIT, then a stray completion
    send(1'b0, 16'h0100, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_start", mem_start, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stray_rsp_valid", rsp_valid, 0);
    end
    send(1'b1, 16'hFFFF, 8'h3C); get_rsp(0, rd, er, lat);
    chk("post_rst_err", er, 0);
    chk("post_rst_wr_count", wr_count, 1);
    send(1'b0, 16'hFFFF, 8'h00); get_rsp(0, rd, er, lat);
    chk("post_rst_rdata", rd, 8'h3C);
    nw = 1; nr = 1;

    // random traffic with random response stalls
    for (int k = 0; k < 256; k++) begin
      logic  rw;
      addr_t a;
      rw = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 16'hFF00 : 16'h0000);
      send(rw, a, 8'($urandom));
      get_rsp($urandom_range(0, 2), rd, er, lat);
      if (rw) nw++; else nr++;
    end
    chk("final_wr_count", wr_count, nw);
    chk("final_rd_count", rd_count, nr);
    chk("final_err_count", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
